// File: rtl/wb_retire_stage_if.sv
// MEM->WB handshake bundle plus the debug trace handshake.
// master = MEM stage / trace consumer side, slave = wb_retire_stage.
interface wb_retire_stage_if #(
    parameter int DATA_W     = 32,
    parameter int RF_ADDR_W  = 5,
    parameter int CSR_ADDR_W = 14
);
    logic                  mem_wb_valid;
    logic                  wb_allowin;
    logic [DATA_W-1:0]     mem_pc;
    logic [DATA_W-1:0]     mem_result;
    logic                  mem_gr_we;
    logic [RF_ADDR_W-1:0]  mem_dest;
    logic                  mem_csr_we;
    logic [CSR_ADDR_W-1:0] mem_csr_waddr;
    logic [DATA_W-1:0]     mem_csr_wmask;
    logic [DATA_W-1:0]     mem_csr_wdata;
    logic                  mem_ertn;
    logic                  mem_exc;
    logic [5:0]            mem_ecode;
    logic [8:0]            mem_esubcode;
    logic                  mem_epoch;

    logic                  debug_wb_valid;
    logic                  debug_wb_ready;
    logic [DATA_W-1:0]     debug_wb_pc;
    logic [DATA_W-1:0]     debug_wb_rf_wdata;
    logic [RF_ADDR_W-1:0]  debug_wb_rf_wnum;
    logic [3:0]            debug_wb_rf_we;

    modport master (
        output mem_wb_valid, mem_pc, mem_result,
        output mem_gr_we, mem_dest,
        output mem_csr_we, mem_csr_waddr,
        output mem_csr_wmask, mem_csr_wdata,
        output mem_ertn, mem_exc, mem_ecode,
        output mem_esubcode, mem_epoch,
        input  wb_allowin,
        input  debug_wb_valid, debug_wb_pc,
        input  debug_wb_rf_wdata, debug_wb_rf_wnum,
        input  debug_wb_rf_we,
        output debug_wb_ready
    );

    modport slave (
        input  mem_wb_valid, mem_pc, mem_result,
        input  mem_gr_we, mem_dest,
        input  mem_csr_we, mem_csr_waddr,
        input  mem_csr_wmask, mem_csr_wdata,
        input  mem_ertn, mem_exc, mem_ecode,
        input  mem_esubcode, mem_epoch,
        output wb_allowin,
        output debug_wb_valid, debug_wb_pc,
        output debug_wb_rf_wdata, debug_wb_rf_wnum,
        output debug_wb_rf_we,
        input  debug_wb_ready
    );
endinterface

// File: rtl/wb_retire_stage.sv
// Writeback/retire stage with epoch flush filter and retire counter.
// WB_TRACE_FIFO_EN adds a trace FIFO with debug_wb_ready back-pressure.
module wb_retire_stage #(
    parameter int DATA_W      = 32,
    parameter int RF_ADDR_W   = 5,
    parameter int CSR_ADDR_W  = 14,
    parameter int TRACE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    wb_retire_stage_if.slave      bus,
    output logic                  rf_we,
    output logic [RF_ADDR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  csr_we,
    output logic [CSR_ADDR_W-1:0] csr_waddr,
    output logic [DATA_W-1:0]     csr_wmask,
    output logic [DATA_W-1:0]     csr_wdata,
    output logic                  wb_exc,
    output logic [5:0]            wb_ecode,
    output logic [8:0]            wb_esubcode,
    output logic [DATA_W-1:0]     wb_pc,
    output logic [DATA_W-1:0]     wb_badvaddr,
    output logic                  ertn_flush,
    output logic                  wb_epoch,
    output logic [31:0]           retire_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     result;
        logic                  gr_we;
        logic [RF_ADDR_W-1:0]  dest;
        logic                  csr_we;
        logic [CSR_ADDR_W-1:0] csr_waddr;
        logic [DATA_W-1:0]     csr_wmask;
        logic [DATA_W-1:0]     csr_wdata;
        logic                  ertn;
        logic                  exc;
        logic [5:0]            ecode;
        logic [8:0]            esubcode;
        logic                  epoch;
    } wb_ent_t;

    wb_ent_t     ent_q, ent_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_epoch_q, wb_epoch_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    logic live;
    logic ready_go;
    logic wb_allowin;

    assign live       = wb_valid_q & (ent_q.epoch == wb_epoch_q);
    assign wb_allowin = ~wb_valid_q | ready_go;

    assign bus.wb_allowin = wb_allowin;
    assign wb_epoch       = wb_epoch_q;
    assign retire_cnt     = retire_cnt_q;

    always_comb begin
        wb_exc      = live & ent_q.exc;
        ertn_flush  = live & ent_q.ertn & ~ent_q.exc;
        csr_we      = live & ent_q.csr_we & ~ent_q.exc;
        rf_we       = live & ent_q.gr_we & ~ent_q.exc
                    & ~ent_q.ertn & ready_go;
        rf_waddr    = wb_valid_q ? ent_q.dest      : '0;
        rf_wdata    = wb_valid_q ? ent_q.result    : '0;
        csr_waddr   = wb_valid_q ? ent_q.csr_waddr : '0;
        csr_wmask   = wb_valid_q ? ent_q.csr_wmask : '0;
        csr_wdata   = wb_valid_q ? ent_q.csr_wdata : '0;
        wb_ecode    = wb_valid_q ? ent_q.ecode     : '0;
        wb_esubcode = wb_valid_q ? ent_q.esubcode  : '0;
        wb_pc       = wb_valid_q ? ent_q.pc        : '0;
        wb_badvaddr = wb_valid_q ? ent_q.result    : '0;
    end

    always_comb begin
        ent_d        = ent_q;
        wb_valid_d   = wb_valid_q;
        wb_epoch_d   = wb_epoch_q ^ (wb_exc | ertn_flush);
        retire_cnt_d = retire_cnt_q;
        if (wb_allowin) begin
            wb_valid_d = bus.mem_wb_valid;
        end
        if (bus.mem_wb_valid & wb_allowin) begin
            ent_d.pc        = bus.mem_pc;
            ent_d.result    = bus.mem_result;
            ent_d.gr_we     = bus.mem_gr_we;
            ent_d.dest      = bus.mem_dest;
            ent_d.csr_we    = bus.mem_csr_we;
            ent_d.csr_waddr = bus.mem_csr_waddr;
            ent_d.csr_wmask = bus.mem_csr_wmask;
            ent_d.csr_wdata = bus.mem_csr_wdata;
            ent_d.ertn      = bus.mem_ertn;
            ent_d.exc       = bus.mem_exc;
            ent_d.ecode     = bus.mem_ecode;
            ent_d.esubcode  = bus.mem_esubcode;
            ent_d.epoch     = bus.mem_epoch;
        end
        if (live & ready_go & ~ent_q.exc) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q        <= '0;
            wb_valid_q   <= 1'b0;
            wb_epoch_q   <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            ent_q        <= ent_d;
            wb_valid_q   <= wb_valid_d;
            wb_epoch_q   <= wb_epoch_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

`ifdef WB_TRACE_FIFO_EN
    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0]    pc;
        logic [RF_ADDR_W-1:0] wnum;
        logic [DATA_W-1:0]    wdata;
    } tr_ent_t;

    tr_ent_t            fifo_q [TRACE_DEPTH];
    tr_ent_t            push_ent;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tr_valid, full, push, pop;

    assign tr_valid = (cnt_q != '0);
    assign full     = (cnt_q == CNT_W'(TRACE_DEPTH));
    assign pop      = tr_valid & bus.debug_wb_ready;
    // A pop frees a slot in the same cycle, so a full FIFO need not stall.
    assign ready_go = ~(live & ent_q.gr_we & ~ent_q.exc & full & ~pop);
    assign push     = rf_we;
    assign push_ent = '{pc: ent_q.pc, wnum: ent_q.dest,
                        wdata: ent_q.result};

    assign bus.debug_wb_valid    = tr_valid;
    assign bus.debug_wb_pc       = fifo_q[rd_ptr_q].pc;
    assign bus.debug_wb_rf_wnum  = fifo_q[rd_ptr_q].wnum;
    assign bus.debug_wb_rf_wdata = fifo_q[rd_ptr_q].wdata;
    assign bus.debug_wb_rf_we    = {4{tr_valid}};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_ent;
    end
`else
    assign ready_go              = 1'b1;
    assign bus.debug_wb_valid    = rf_we;
    assign bus.debug_wb_pc       = wb_pc;
    assign bus.debug_wb_rf_wnum  = rf_waddr;
    assign bus.debug_wb_rf_wdata = rf_wdata;
    assign bus.debug_wb_rf_we    = {4{rf_we}};
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed bench for wb_retire_stage (both trace configurations).
module tb_wb_retire_stage;

    localparam int DATA_W     = 32;
    localparam int RF_ADDR_W  = 5;
    localparam int CSR_ADDR_W = 14;

    logic clk;
    logic reset;
    logic                  rf_we;
    logic [RF_ADDR_W-1:0]  rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic                  csr_we;
    logic [CSR_ADDR_W-1:0] csr_waddr;
    logic [DATA_W-1:0]     csr_wmask;
    logic [DATA_W-1:0]     csr_wdata;
    logic                  wb_exc;
    logic [5:0]            wb_ecode;
    logic [8:0]            wb_esubcode;
    logic [DATA_W-1:0]     wb_pc;
    logic [DATA_W-1:0]     wb_badvaddr;
    logic                  ertn_flush;
    logic                  wb_epoch;
    logic [31:0]           retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    wb_retire_stage_if #(
        .DATA_W(DATA_W), .RF_ADDR_W(RF_ADDR_W),
        .CSR_ADDR_W(CSR_ADDR_W)
    ) bus ();

    wb_retire_stage #(
        .DATA_W(DATA_W), .RF_ADDR_W(RF_ADDR_W),
        .CSR_ADDR_W(CSR_ADDR_W), .TRACE_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .csr_we(csr_we),
        .csr_waddr(csr_waddr), .csr_wmask(csr_wmask),
        .csr_wdata(csr_wdata), .wb_exc(wb_exc),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
        .ertn_flush(ertn_flush), .wb_epoch(wb_epoch),
        .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.mem_wb_valid  = 1'b0;
        bus.mem_pc        = '0;
        bus.mem_result    = '0;
        bus.mem_gr_we     = 1'b0;
        bus.mem_dest      = '0;
        bus.mem_csr_we    = 1'b0;
        bus.mem_csr_waddr = '0;
        bus.mem_csr_wmask = '0;
        bus.mem_csr_wdata = '0;
        bus.mem_ertn      = 1'b0;
        bus.mem_exc       = 1'b0;
        bus.mem_ecode     = '0;
        bus.mem_esubcode  = '0;
        bus.mem_epoch     = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc,
                         input logic gr_we,
                         input logic [4:0] dest,
                         input logic [31:0] res,
                         input logic exc,
                         input logic [5:0] ecode,
                         input logic ertn,
                         input logic ep);
        idle();
        bus.mem_wb_valid = 1'b1;
        bus.mem_pc       = pc;
        bus.mem_gr_we    = gr_we;
        bus.mem_dest     = dest;
        bus.mem_result   = res;
        bus.mem_exc      = exc;
        bus.mem_ecode    = ecode;
        bus.mem_ertn     = ertn;
        bus.mem_epoch    = ep;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.debug_wb_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (bus.wb_allowin !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_allowin: got %b want 1", bus.wb_allowin);
        end
        n_checks++;
        if (bus.debug_wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_dbg_valid: got %b want 0", bus.debug_wb_valid);
        end
        n_checks++;
        if (wb_epoch !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_epoch: got %b want 0", wb_epoch);
        end
        n_checks++;
        if (retire_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_retire: got %0d want 0", retire_cnt);
        end
        n_checks++;
        if (rf_we !== 1'b0 || wb_exc !== 1'b0 || wb_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_outs: rf_we %b exc %b pc %h want 0",
                     rf_we, wb_exc, wb_pc);
        end
    endtask

    task automatic test_back_to_back();
        issue(32'h1c00_0000, 1'b1, 5'd1, 32'd5, 1'b0, 6'd0, 1'b0, 1'b0);
        step();
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'd5) begin
            n_fail++;
            $display("FAIL b2b_w1: got we %b a %0d d %0d want 1 1 5",
                     rf_we, rf_waddr, rf_wdata);
        end
`ifndef WB_TRACE_FIFO_EN
        n_checks++;
        if (bus.debug_wb_valid !== 1'b1 ||
            bus.debug_wb_pc !== 32'h1c00_0000) begin
            n_fail++;
            $display("FAIL b2b_tr1: got v %b pc %h want 1 1c000000",
                     bus.debug_wb_valid, bus.debug_wb_pc);
        end
`endif
        issue(32'h1c00_0004, 1'b1, 5'd2, 32'd7, 1'b0, 6'd0, 1'b0, 1'b0);
        step();
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'd7) begin
            n_fail++;
            $display("FAIL b2b_w2: got we %b a %0d d %0d want 1 2 7",
                     rf_we, rf_waddr, rf_wdata);
        end
`ifdef WB_TRACE_FIFO_EN
        n_checks++;
        if (bus.debug_wb_valid !== 1'b1 ||
            bus.debug_wb_pc !== 32'h1c00_0000 ||
            bus.debug_wb_rf_wdata !== 32'd5) begin
            n_fail++;
            $display("FAIL b2b_tr1: got v %b pc %h d %0d want 1 1c000000 5",
                     bus.debug_wb_valid, bus.debug_wb_pc,
                     bus.debug_wb_rf_wdata);
        end
`else
        n_checks++;
        if (bus.debug_wb_pc !== 32'h1c00_0004 ||
            bus.debug_wb_rf_wnum !== 5'd2 ||
            bus.debug_wb_rf_we !== 4'hf) begin
            n_fail++;
            $display("FAIL b2b_tr2: got pc %h n %0d we %h want 1c000004 2 f",
                     bus.debug_wb_pc, bus.debug_wb_rf_wnum,
                     bus.debug_wb_rf_we);
        end
`endif
        idle();
        step();
        n_checks++;
        if (rf_we !== 1'b0 || retire_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b_cnt: got we %b cnt %0d want 0 2",
                     rf_we, retire_cnt);
        end
        step();
    endtask

    task automatic test_csr_write();
        issue(32'h1c00_0008, 1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        bus.mem_csr_we    = 1'b1;
        bus.mem_csr_waddr = 14'h0006;
        bus.mem_csr_wmask = 32'h0000_00ff;
        bus.mem_csr_wdata = 32'h0000_0055;
        step();
        n_checks++;
        if (csr_we !== 1'b1 || csr_waddr !== 14'h0006 ||
            csr_wmask !== 32'hff || csr_wdata !== 32'h55) begin
            n_fail++;
            $display("FAIL csr_wr: got we %b a %h m %h d %h want 1 6 ff 55",
                     csr_we, csr_waddr, csr_wmask, csr_wdata);
        end
        idle();
        step();
        n_checks++;
        if (csr_we !== 1'b0 || retire_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL csr_cnt: got we %b cnt %0d want 0 3",
                     csr_we, retire_cnt);
        end
    endtask

    task automatic test_exception();
        issue(32'h1c00_0010, 1'b0, 5'd0, 32'd0, 1'b1, 6'h0b, 1'b0, 1'b0);
        step();
        n_checks++;
        if (wb_exc !== 1'b1 || wb_ecode !== 6'h0b ||
            wb_pc !== 32'h1c00_0010) begin
            n_fail++;
            $display("FAIL exc_report: got exc %b ec %h pc %h want 1 0b 1c000010",
                     wb_exc, wb_ecode, wb_pc);
        end
        issue(32'h1c00_0014, 1'b1, 5'd4, 32'd1, 1'b0, 6'd0, 1'b0, 1'b0);
        step();
        n_checks++;
        if (wb_exc !== 1'b0 || wb_epoch !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_pulse: got exc %b epoch %b want 0 1",
                     wb_exc, wb_epoch);
        end
        n_checks++;
        if (rf_we !== 1'b0 || bus.debug_wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_young1: got rf_we %b dbg %b want 0 0",
                     rf_we, bus.debug_wb_valid);
        end
        issue(32'h1c00_0018, 1'b1, 5'd5, 32'd2, 1'b0, 6'd0, 1'b0, 1'b0);
        step();
        n_checks++;
        if (rf_we !== 1'b0 || wb_exc !== 1'b0 ||
            bus.debug_wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_young2: got rf_we %b exc %b dbg %b want 0 0 0",
                     rf_we, wb_exc, bus.debug_wb_valid);
        end
        idle();
        step();
        n_checks++;
        if (retire_cnt !== 32'd3 || wb_epoch !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_cnt: got cnt %0d epoch %b want 3 1",
                     retire_cnt, wb_epoch);
        end
    endtask

    task automatic test_reset_mid();
        issue(32'h1c00_0020, 1'b1, 5'd7, 32'd77, 1'b0, 6'd0, 1'b0, 1'b1);
        step();
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
            n_fail++;
            $display("FAIL rmid_pre: got we %b a %0d want 1 7",
                     rf_we, rf_waddr);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        n_checks++;
        if (bus.debug_wb_valid !== 1'b0 || wb_epoch !== 1'b0 ||
            retire_cnt !== 32'd0 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_post: got dbg %b ep %b cnt %0d we %b want 0 0 0 0",
                     bus.debug_wb_valid, wb_epoch, retire_cnt, rf_we);
        end
    endtask

    task automatic test_ale();
        issue(32'h1c00_0024, 1'b1, 5'd6, 32'h1c00_0003,
              1'b1, 6'h09, 1'b0, 1'b0);
        bus.mem_csr_we = 1'b1;
        step();
        n_checks++;
        if (wb_badvaddr !== 32'h1c00_0003 || wb_exc !== 1'b1) begin
            n_fail++;
            $display("FAIL ale_bad: got bva %h exc %b want 1c000003 1",
                     wb_badvaddr, wb_exc);
        end
        n_checks++;
        if (rf_we !== 1'b0 || csr_we !== 1'b0) begin
            n_fail++;
            $display("FAIL ale_we: got rf %b csr %b want 0 0",
                     rf_we, csr_we);
        end
        idle();
        step();
        n_checks++;
        if (wb_epoch !== 1'b1 || retire_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL ale_post: got ep %b cnt %0d want 1 0",
                     wb_epoch, retire_cnt);
        end
    endtask

    task automatic test_ertn();
        issue(32'h1c00_0030, 1'b0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b1, 1'b0);
        step();
        n_checks++;
        if (ertn_flush !== 1'b1 || rf_we !== 1'b0 || wb_exc !== 1'b0) begin
            n_fail++;
            $display("FAIL ertn_pulse: got fl %b we %b exc %b want 1 0 0",
                     ertn_flush, rf_we, wb_exc);
        end
        issue(32'h1c00_0034, 1'b1, 5'd3, 32'd9, 1'b0, 6'd0, 1'b0, 1'b1);
        step();
        n_checks++;
        if (ertn_flush !== 1'b0 || wb_epoch !== 1'b1) begin
            n_fail++;
            $display("FAIL ertn_once: got fl %b ep %b want 0 1",
                     ertn_flush, wb_epoch);
        end
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'd9) begin
            n_fail++;
            $display("FAIL ertn_r3: got we %b a %0d d %0d want 1 3 9",
                     rf_we, rf_waddr, rf_wdata);
        end
        idle();
        step();
        n_checks++;
        if (retire_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL ertn_cnt: got %0d want 2", retire_cnt);
        end
        step();
    endtask

    task automatic test_fifo_backpressure();
`ifdef WB_TRACE_FIFO_EN
        int got;
        bus.debug_wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(32'h1c00_0100 + 32'(4 * i), 1'b1, 5'(8 + i),
                  32'(100 + i), 1'b0, 6'd0, 1'b0, 1'b1);
            step();
        end
        n_checks++;
        if (bus.wb_allowin !== 1'b0 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: got allowin %b we %b want 0 0",
                     bus.wb_allowin, rf_we);
        end
        issue(32'h1c00_0114, 1'b1, 5'd13, 32'd105,
              1'b0, 6'd0, 1'b0, 1'b1);
        repeat (2) step();
        n_checks++;
        if (bus.wb_allowin !== 1'b0 || bus.debug_wb_pc !== 32'h1c00_0100) begin
            n_fail++;
            $display("FAIL bp_hold: got allowin %b pc %h want 0 1c000100",
                     bus.wb_allowin, bus.debug_wb_pc);
        end
        bus.debug_wb_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.wb_allowin !== 1'b1 || rf_we !== 1'b1 ||
            rf_waddr !== 5'd12) begin
            n_fail++;
            $display("FAIL bp_fullpop: got allowin %b we %b a %0d want 1 1 12",
                     bus.wb_allowin, rf_we, rf_waddr);
        end
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.debug_wb_valid === 1'b1) begin
                n_checks++;
                if (bus.debug_wb_pc !== 32'h1c00_0100 + 32'(4 * got) ||
                    bus.debug_wb_rf_wdata !== 32'(100 + got)) begin
                    n_fail++;
                    $display("FAIL bp_order%0d: got pc %h d %0d want %h %0d",
                             got, bus.debug_wb_pc, bus.debug_wb_rf_wdata,
                             32'h1c00_0100 + 32'(4 * got), 100 + got);
                end
                got++;
            end
            step();
            if (c == 0) idle();
        end
        n_checks++;
        if (got != 6) begin
            n_fail++;
            $display("FAIL bp_count: got %0d entries want 6", got);
        end
        n_checks++;
        if (retire_cnt !== 32'd8) begin
            n_fail++;
            $display("FAIL bp_cnt: got %0d want 8", retire_cnt);
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        bus.debug_wb_ready = 1'b1;
        idle();
        test_reset();
        test_back_to_back();
        test_csr_write();
        test_exception();
        test_reset_mid();
        test_ale();
        test_reset();
        test_ertn();
        test_fifo_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
